// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-macro signals seen by mem_port_arbiter.
// master = arbiter side, slave = core pipeline plus memory macro side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Handshake: a requester raises *_req with a stable payload and holds both
    // until its one-cycle *_ack; a req still high the cycle after ack is a new
    // transaction. mem_en is a one-cycle strobe; mem_rdata is valid MEM_LAT
    // cycles after it, with no back-pressure from the memory.
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_ack;
    logic [DW-1:0]   i_rdata;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic            d_ack;
    logic [DW-1:0]   d_rdata;

    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;

    logic            busy;
    logic [1:0]      dbg_state;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy, dbg_state
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy, dbg_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// load/store, data first, with a starvation guard that eventually forces fetch.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);
    localparam logic [WCW-1:0] WAIT_INIT  = WCW'(MEM_LAT - 1);

    state_t          r_state;
    logic [SCW-1:0]  r_starve_cnt;
    logic [WCW-1:0]  r_wait_cnt;
    logic            r_grant_d;

    logic            r_i_ack;
    logic [DW-1:0]   r_i_rdata;
    logic            r_d_ack;
    logic [DW-1:0]   r_d_rdata;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW/8-1:0] r_mem_be;
    logic            r_busy;

    logic            w_pick_d;
    logic            w_pick_i;

    // Data wins unless fetch is also waiting and has been passed over STARVE_MAX times.
    assign w_pick_d = bus.d_req && (!bus.i_req || (r_starve_cnt < STARVE_LIM));
    assign w_pick_i = bus.i_req && !w_pick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
            r_grant_d    <= 1'b0;
            r_i_ack      <= 1'b0;
            r_i_rdata    <= '0;
            r_d_ack      <= 1'b0;
            r_d_rdata    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;

            case (r_state)
                IDLE: begin
                    if (!bus.i_req || w_pick_i) begin
                        r_starve_cnt <= '0;
                    end else if (w_pick_d && (r_starve_cnt != STARVE_LIM)) begin
                        r_starve_cnt <= r_starve_cnt + SCW'(1);
                    end

                    // The mem_* registers double as the payload latch for the ISSUE cycle.
                    if (w_pick_d) begin
                        r_grant_d   <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        r_mem_be    <= bus.d_be;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end else if (w_pick_i) begin
                        r_grant_d   <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= bus.i_addr;
                        r_mem_be    <= '1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_wait_cnt <= WAIT_INIT;
                    r_state    <= WAIT;
                end

                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        if (r_grant_d) begin
                            r_d_rdata <= bus.mem_rdata;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_i_rdata <= bus.mem_rdata;
                            r_i_ack   <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WCW'(1);
                    end
                end

                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack     = r_i_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each backed by a small byte-enabled memory model.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models, preloaded on reset.
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] rd1;
    logic [31:0] p1, p2, p3;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'h0;
            mem1[64] <= 32'hDEADBEEF;
            rd1 <= 32'h0;
        end else if (bus1.mem_en) begin
            rd1 <= mem1[bus1.mem_addr[9:2]];
            if (bus1.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus1.mem_be[b]) mem1[bus1.mem_addr[9:2]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 32'h0;
            mem3[16] <= 32'hCAFEF00D;
            mem3[64] <= 32'h11111111;
            p1 <= 32'h0;
            p2 <= 32'h0;
            p3 <= 32'h0;
        end else begin
            p1 <= bus3.mem_en ? mem3[bus3.mem_addr[9:2]] : 32'h0;
            p2 <= p1;
            p3 <= p2;
        end
    end

    assign bus1.mem_rdata = rd1;
    assign bus3.mem_rdata = p3;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [9:0] order;
    logic       exp_i;
    int         cyc;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_be = '0;
        bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        bus3.d_addr = '0; bus3.d_wdata = '0; bus3.d_be = '0;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("rst_i_ack",   64'(bus1.i_ack),     64'd0);
        check("rst_d_ack",   64'(bus1.d_ack),     64'd0);
        check("rst_mem_en",  64'(bus1.mem_en),    64'd0);
        check("rst_busy",    64'(bus1.busy),      64'd0);
        check("rst_i_rdata", 64'(bus1.i_rdata),   64'd0);
        check("rst_d_rdata", 64'(bus1.d_rdata),   64'd0);
        check("rst_state",   64'(bus1.dbg_state), 64'd0);
        check("rst_busy3",   64'(bus3.busy),      64'd0);

        // Single fetch at 0x100
        bus1.i_req = 1'b1; bus1.i_addr = 32'h100;
        tick(1);
        check("f_mem_en",   64'(bus1.mem_en),   64'd1);
        check("f_mem_we",   64'(bus1.mem_we),   64'd0);
        check("f_mem_addr", 64'(bus1.mem_addr), 64'h100);
        check("f_busy",     64'(bus1.busy),     64'd1);
        tick(1);
        check("f_mem_en_off", 64'(bus1.mem_en), 64'd0);
        check("f_ack_early",  64'(bus1.i_ack),  64'd0);
        tick(1);
        check("f_ack",    64'(bus1.i_ack),   64'd1);
        check("f_rdata",  64'(bus1.i_rdata), 64'hDEADBEEF);
        check("f_d_ack0", 64'(bus1.d_ack),   64'd0);
        bus1.i_req = 1'b0;
        tick(1);
        check("f_busy_low", 64'(bus1.busy),  64'd0);
        check("f_ack_low",  64'(bus1.i_ack), 64'd0);

        // Store 0x12345678 with be=0011 at 0x40
        bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h40;
        bus1.d_wdata = 32'h12345678; bus1.d_be = 4'b0011;
        tick(1);
        check("st_mem_en",    64'(bus1.mem_en),    64'd1);
        check("st_mem_we",    64'(bus1.mem_we),    64'd1);
        check("st_mem_be",    64'(bus1.mem_be),    64'b0011);
        check("st_mem_addr",  64'(bus1.mem_addr),  64'h40);
        check("st_mem_wdata", 64'(bus1.mem_wdata), 64'h12345678);
        tick(1);
        check("st_ack_early", 64'(bus1.d_ack), 64'd0);
        tick(1);
        check("st_ack", 64'(bus1.d_ack), 64'd1);
        bus1.d_req = 1'b0;
        tick(1);
        check("st_ack_width", 64'(bus1.d_ack), 64'd0);

        // Load back from 0x40
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_wdata = '0; bus1.d_be = '0;
        tick(1);
        check("ld_mem_we", 64'(bus1.mem_we), 64'd0);
        tick(2);
        check("ld_ack",   64'(bus1.d_ack),   64'd1);
        check("ld_rdata", 64'(bus1.d_rdata), 64'h00005678);
        bus1.d_req = 1'b0;
        tick(1);
        check("ld_ack_width", 64'(bus1.d_ack), 64'd0);

        // Simultaneous fetch and load: data first, fetch next
        bus1.i_req = 1'b1; bus1.i_addr = 32'h100;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h40;
        tick(1);
        check("both_first_addr", 64'(bus1.mem_addr), 64'h40);
        tick(2);
        check("both_d_ack",   64'(bus1.d_ack),   64'd1);
        check("both_i_ack0",  64'(bus1.i_ack),   64'd0);
        check("both_d_rdata", 64'(bus1.d_rdata), 64'h00005678);
        bus1.d_req = 1'b0;
        tick(1);
        check("both_idle_i_ack0", 64'(bus1.i_ack), 64'd0);
        tick(1);
        check("both_second_en",   64'(bus1.mem_en),   64'd1);
        check("both_second_addr", 64'(bus1.mem_addr), 64'h100);
        tick(2);
        check("both_i_ack",   64'(bus1.i_ack),   64'd1);
        check("both_d_ack0",  64'(bus1.d_ack),   64'd0);
        check("both_i_rdata", 64'(bus1.i_rdata), 64'hDEADBEEF);
        bus1.i_req = 1'b0;
        tick(1);

        // Starvation guard: expected order D,D,D,D,I,D,D,D,D,I (bit k = 1 means fetch)
        order = 10'b10_0001_0000;
        bus1.i_req = 1'b1; bus1.i_addr = 32'h100;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            exp_i = order[k];
            tick(1);
            check($sformatf("starve_addr_%0d", k), 64'(bus1.mem_addr), exp_i ? 64'h100 : 64'h80);
            tick(2);
            check($sformatf("starve_i_ack_%0d", k), 64'(bus1.i_ack), 64'(exp_i));
            check($sformatf("starve_d_ack_%0d", k), 64'(bus1.d_ack), 64'(!exp_i));
            if (k == 9) begin
                bus1.i_req = 1'b0;
                bus1.d_req = 1'b0;
            end
            tick(1);
        end
        check("starve_idle", 64'(bus1.busy), 64'd0);

        // MEM_LAT = 3: ack five cycles after the request is sampled
        bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h40;
        tick(1);
        check("lat3_mem_en", 64'(bus3.mem_en), 64'd1);
        tick(1);
        check("lat3_mem_en_off", 64'(bus3.mem_en), 64'd0);
        tick(2);
        check("lat3_ack_early", 64'(bus3.d_ack), 64'd0);
        check("lat3_mem_en_off2", 64'(bus3.mem_en), 64'd0);
        tick(1);
        check("lat3_ack",   64'(bus3.d_ack),   64'd1);
        check("lat3_rdata", 64'(bus3.d_rdata), 64'hCAFEF00D);
        bus3.d_req = 1'b0;
        tick(1);
        check("lat3_ack_width", 64'(bus3.d_ack), 64'd0);

        // Reset during WAIT of a fetch
        bus3.i_req = 1'b1; bus3.i_addr = 32'h100;
        tick(1);
        check("abort_issue", 64'(bus3.mem_en), 64'd1);
        tick(1);
        check("abort_in_wait", 64'(bus3.dbg_state), 64'd2);
        rst = 1'b1;
        bus3.i_req = 1'b0;
        tick(1);
        check("abort_busy",   64'(bus3.busy),      64'd0);
        check("abort_mem_en", 64'(bus3.mem_en),    64'd0);
        check("abort_i_ack",  64'(bus3.i_ack),     64'd0);
        check("abort_state",  64'(bus3.dbg_state), 64'd0);
        rst = 1'b0;
        tick(1);
        check("abort_i_ack_t4", 64'(bus3.i_ack), 64'd0);
        tick(1);
        check("abort_i_ack_t5",  64'(bus3.i_ack),   64'd0);
        check("abort_i_rdata",   64'(bus3.i_rdata), 64'd0);

        // New load after reset completes normally
        bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h40;
        cyc = 0;
        while (!bus3.d_ack && cyc < 20) begin
            tick(1);
            cyc++;
        end
        check("post_rst_latency", 64'(cyc), 64'd5);
        check("post_rst_rdata", 64'(bus3.d_rdata), 64'hCAFEF00D);
        bus3.d_req = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the CPU's single-port unified memory between two requesters: instruction fetch (read-only) and load/store (read/write).
- Sits between the core pipeline and the memory macro inside top_inst.
- Handles one transaction at a time through a fixed-latency memory.
- Uses data-priority arbitration with a starvation guard for fetch.
- Returns a one-cycle ack with read data to the requester that won arbitration.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; must be >= 1.
- STARVE_MAX, 4, max consecutive data grants while i_req is pending before fetch is forced; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  AW  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle fetch completion.
- i_rdata  out  DW  fetch data; valid when i_ack is high.
- d_req  in  1  load/store request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_be  in  DW/8  store byte enables.
- d_ack  out  1  one-cycle data completion.
- d_rdata  out  DW  load data; valid when d_ack is high.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_be  out  DW/8  memory byte enables.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - State is IDLE; starve_cnt = 0.
  - All outputs are 0, including i_rdata and d_rdata.
- FSM states and transitions:
  - IDLE: arbitrate when any request is present; register the winner, address, we, wdata and be; go to ISSUE. With no request, stay in IDLE.
  - ISSUE (1 cycle): mem_en = 1; mem_we = d_we for a data winner, 0 for fetch. Load wait_cnt = MEM_LAT - 1 and go to WAIT.
  - WAIT: decrement wait_cnt. On the cycle mem_rdata is valid (MEM_LAT cycles after ISSUE), capture it into the winner's rdata register and go to RESP.
  - RESP (1 cycle): assert the winner's ack; go to IDLE.
- Outputs:
  - All outputs are registered.
  - mem_* are 0 outside ISSUE.
  - The non-winner's ack stays 0.
  - Rdata registers hold their value until the next capture.
- Latency: request sampled in IDLE at cycle T produces mem_en at T+1 and ack at T+2+MEM_LAT. With MEM_LAT = 1, back-to-back throughput is one transaction per 4 cycles.
- Stores follow the same timing. d_rdata for a store is don't-care but is still updated from mem_rdata.
- Arbitration (IDLE only):
  - Only one request present: grant it.
  - Both present and starve_cnt < STARVE_MAX: grant data and increment starve_cnt.
  - Both present and starve_cnt == STARVE_MAX: grant fetch.
  - starve_cnt clears on any fetch grant, and whenever i_req is low at arbitration.
  - starve_cnt saturates; it never wraps.
- Handshake rules:
  - A requester keeps req and payload stable from assertion through its ack cycle.
  - A req still high in the cycle after ack is treated as a new transaction.
  - Request changes during ISSUE/WAIT/RESP are ignored, because the payload is latched in IDLE.
- Reset mid-operation: the next edge returns the FSM to IDLE. No ack is issued for the aborted transaction, and mem_en is low from that edge on.

Test Plan:
- Single fetch, MEM_LAT = 1, i_addr = 0x100, memory returns 0xDEADBEEF -> mem_en=1, mem_we=0 at T+1; i_ack=1 with i_rdata=0xDEADBEEF at T+3; busy low at T+4.
- Store then load at 0x40: d_wdata = 0x12345678, d_be = 4'b0011, then load -> store cycle shows mem_we=1, mem_be=0011; load returns 0x00005678 (memory model was zero-initialised); each d_ack is exactly one cycle wide.
- Simultaneous i_req and d_req with a single data request -> data is served first; fetch is served in the next IDLE; i_ack never asserts in the same cycle as d_ack.
- Starvation, STARVE_MAX = 4: d_req held for 10 back-to-back requests, i_req held continuously -> grant order D,D,D,D,I,D,D,D,D,I.
- MEM_LAT = 3 -> ack arrives exactly 5 cycles after the request is sampled; mem_en is high for one cycle only.
- rst asserted during WAIT of a fetch -> no i_ack; busy=0 and mem_en=0 after that edge. A new d_req after rst releases completes normally.
